// File: rtl/fpu10_pkg.sv
// rtl/fpu10_pkg.sv - fp10 format constants, opcodes and serial front-end state encoding.
package fpu10_pkg;

    localparam int EXP_W  = 4;
    localparam int MAN_W  = 5;
    localparam int FP_W   = 10;
    localparam int BEAT_W = 5;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;

    localparam logic [EXP_W-1:0] EXP_BIAS = 4'd7;
    localparam logic [EXP_W-1:0] EXP_MAX  = 4'hF;
    localparam logic [FP_W-1:0]  FP10_NAN = 10'h3FF;

    typedef enum logic [2:0] {
        S_OP,
        S_AHI,
        S_ALO,
        S_BHI,
        S_BLO,
        S_EXEC,
        S_YHI,
        S_YLO
    } if_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    // Round-to-nearest-even; a mantissa carry ripples into the exponent and
    // an exponent reaching EXP_MAX lands exactly on infinity.
    function automatic logic [FP_W-1:0] round_pack(
        input logic             s,
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] m,
        input logic             g,
        input logic             st
    );
        logic inc;
        inc = g & (st | m[0]);
        return {s, {e, m} + {{(EXP_W+MAN_W-1){1'b0}}, inc}};
    endfunction

endpackage

// File: rtl/fpu_10.sv
// rtl/fpu_10.sv - combinational fp10 add/subtract/multiply core; denormals flush to zero.
module fpu_10
    import fpu10_pkg::*;
(
    input  logic [3:0]      sel_i,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] y_o
);

    logic             sa, sb, sbe;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa  = a_i[9];
    assign ea  = a_i[8:5];
    assign ma  = a_i[4:0];
    assign sb  = b_i[9];
    assign eb  = b_i[8:5];
    assign mb  = b_i[4:0];
    assign sbe = sb ^ (sel_i == OP_SUB);

    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    // Add path: significands carry three guard bits below the mantissa.
    logic             a_big, rs, found;
    logic [EXP_W-1:0] be, se, d, lz;
    logic [8:0]       bs, ss, al, df;
    logic [9:0]       sum;
    logic [7:0]       nrm;
    logic [FP_W-1:0]  y_add;

    always_comb begin
        a_big = {ea, ma} >= {eb, mb};
        be    = a_big ? ea : eb;
        se    = a_big ? eb : ea;
        bs    = a_big ? {1'b1, ma, 3'b000} : {1'b1, mb, 3'b000};
        ss    = a_big ? {1'b1, mb, 3'b000} : {1'b1, ma, 3'b000};
        rs    = a_big ? sa : sbe;
        d     = be - se;
        al    = ss >> d;
        sum   = {1'b0, bs} + {1'b0, al};
        df    = bs - al;
        lz    = '0;
        found = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (!found && df[i]) begin
                lz    = 4'(8 - i);
                found = 1'b1;
            end
        end
        nrm = 8'(df << lz);

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe)))
            y_add = FP10_NAN;
        else if (a_inf)
            y_add = {sa, EXP_MAX, 5'd0};
        else if (b_inf)
            y_add = {sbe, EXP_MAX, 5'd0};
        else if (a_zero && b_zero)
            y_add = {sa & sbe, 9'd0};
        else if (a_zero)
            y_add = {sbe, eb, mb};
        else if (b_zero)
            y_add = a_i;
        else if (sa == sbe) begin
            if (sum[9])
                y_add = (be == 4'hE) ? {rs, EXP_MAX, 5'd0}
                                     : round_pack(rs, be + 4'd1, sum[8:4], sum[3], |sum[2:0]);
            else
                y_add = round_pack(rs, be, sum[7:3], sum[2], |sum[1:0]);
        end
        else if (!found || (lz >= be))
            y_add = '0;
        else
            y_add = round_pack(rs, be - lz, nrm[7:3], nrm[2], |nrm[1:0]);
    end

    // Multiply path: 6x6 significand product, exponent kept unbiased-plus-bias.
    logic            sx;
    logic [11:0]     p;
    logic [5:0]      e_res;
    logic [FP_W-1:0] y_mul;

    always_comb begin
        sx    = sa ^ sb;
        p     = {6'd0, 1'b1, ma} * {6'd0, 1'b1, mb};
        e_res = {2'b00, ea} + {2'b00, eb} + {5'd0, p[11]};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            y_mul = FP10_NAN;
        else if (a_inf || b_inf)
            y_mul = {sx, EXP_MAX, 5'd0};
        else if (a_zero || b_zero || (e_res <= {2'b00, EXP_BIAS}))
            y_mul = {sx, 9'd0};
        else if (e_res >= 6'd22)
            y_mul = {sx, EXP_MAX, 5'd0};
        else if (p[11])
            y_mul = round_pack(sx, 4'(e_res - 6'd7), p[10:6], p[5], |p[4:0]);
        else
            y_mul = round_pack(sx, 4'(e_res - 6'd7), p[9:5], p[4], |p[3:0]);
    end

    always_comb begin
        y_o = FP10_NAN;
        case (sel_i)
            OP_ADD, OP_SUB: y_o = y_add;
            OP_MUL:         y_o = y_mul;
            default:        y_o = FP10_NAN;
        endcase
    end

endmodule

// File: rtl/fpu_10_serial_if.sv
// rtl/fpu_10_serial_if.sv - 5-bit beat serial front end: opcode + two operands in, result out.
module fpu_10_serial_if
    import fpu10_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    if_state_t         state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [FP_W-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
    logic [FP_W-1:0]   core_y;
    logic              in_ready_q, out_valid_q, busy_q;
    logic [BEAT_W-1:0] out_data_q;
    logic              in_fire, out_fire;

    fpu_10 u_core (
        .sel_i (sel_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .y_o   (core_y)
    );

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        case (state_q)
            S_OP:   if (in_fire) begin sel_d = in_data[3:0];   state_d = S_AHI;  end
            S_AHI:  if (in_fire) begin a_d[9:5] = in_data;     state_d = S_ALO;  end
            S_ALO:  if (in_fire) begin a_d[4:0] = in_data;     state_d = S_BHI;  end
            S_BHI:  if (in_fire) begin b_d[9:5] = in_data;     state_d = S_BLO;  end
            S_BLO:  if (in_fire) begin b_d[4:0] = in_data;     state_d = S_EXEC; end
            S_EXEC: begin
                y_d     = op_legal(sel_q) ? core_y : FP10_NAN;
                state_d = S_YHI;
            end
            S_YHI:  if (out_fire) state_d = S_YLO;
            S_YLO:  if (out_fire) state_d = S_OP;
            default: state_d = S_OP;
        endcase
    end

    // Handshake outputs are registered from the next state so neither stream
    // sees a combinational path from the other.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_OP;
            sel_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            in_ready_q  <= state_d inside {S_OP, S_AHI, S_ALO, S_BHI, S_BLO};
            out_valid_q <= (state_d == S_YHI) || (state_d == S_YLO);
            out_data_q  <= (state_d == S_YHI) ? y_d[9:5] :
                           (state_d == S_YLO) ? y_d[4:0] : '0;
            busy_q      <= (state_d != S_OP);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_10_serial_if.sv
// tb/tb_fpu_10_serial_if.sv - scoreboard bench for the fp10 serial front end.
module tb_fpu_10_serial_if;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    localparam logic [9:0] F_ONE   = 10'h0E0;
    localparam logic [9:0] F_TWO   = 10'h100;
    localparam logic [9:0] F_1P5   = 10'h0F0;
    localparam logic [9:0] F_THREE = 10'h110;
    localparam logic [9:0] F_HALF  = 10'h0C0;
    localparam logic [9:0] F_NAN   = 10'h3FF;

    always #5 clock = ~clock;

    fpu_10_serial_if dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic send_beat(input logic [4:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 5'h15;
    endtask

    task automatic send_txn(input logic [4:0] op_beat, input logic [9:0] a,
                            input logic [9:0] b, input logic [9:0] y, input int gap);
        logic [4:0] beats [5];
        beats[0] = op_beat;
        beats[1] = a[9:5];
        beats[2] = a[4:0];
        beats[3] = b[9:5];
        beats[4] = b[4:0];
        exp_q.push_back(y[9:5]);
        exp_q.push_back(y[4:0]);
        for (int i = 0; i < 5; i++) begin
            send_beat(beats[i]);
            if (i < 4) repeat (gap) @(negedge clock);
        end
    endtask

    task automatic recv_all();
        int n = 0;
        logic [4:0] e;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 60) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_beat: out_data=%h required %h", out_data, e);
                end
            end
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL recv_timeout: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (out_data !== 5'h00) begin errors++; $display("FAIL reset_out_data: got %h required 00", out_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        // reset wins over an opcode handshake in the same cycle
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'h01;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority: busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
    endtask

    task automatic test_add();
        send_txn(5'h01, F_ONE, F_ONE, F_TWO, 0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exec_cycle: out_valid=%b in_ready=%b busy=%b required 0 0 1",
                     out_valid, in_ready, busy);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency: out_valid=%b required 1", out_valid); end
        recv_all();
        send_txn(5'h01, F_1P5, F_1P5, F_THREE, 0);
        recv_all();
    endtask

    task automatic test_sub();
        send_txn(5'h02, F_ONE, F_ONE, 10'h000, 0);
        recv_all();
        send_txn(5'h02, F_TWO, F_1P5, F_HALF, 0);
        recv_all();
    endtask

    task automatic test_mul();
        send_txn(5'h04, F_TWO, F_1P5, F_THREE, 0);
        recv_all();
        send_txn(5'h04, 10'h000, F_TWO, 10'h000, 0);
        recv_all();
    endtask

    task automatic test_specials();
        send_txn(5'h01, F_NAN, F_ONE, F_NAN, 0);
        recv_all();
        send_txn(5'h03, F_ONE, F_ONE, F_NAN, 0);
        recv_all();
    endtask

    task automatic test_backpressure();
        int n = 0;
        send_txn(5'h01, F_ONE, F_ONE, F_TWO, 0);
        out_ready = 1'b0;
        while (!out_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 5'h01;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 5'h08 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_yhi: out_valid=%b out_data=%h in_ready=%b required 1 08 0",
                         out_valid, out_data, in_ready);
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        recv_all();
    endtask

    task automatic test_gapped_input();
        // in_data[4] of the opcode beat is don't-care
        send_txn(5'h11, F_ONE, F_ONE, F_TWO, 2);
        recv_all();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        send_beat(5'h04);
        send_beat(F_TWO[9:5]);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 5'h00) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b in_ready=%b out_valid=%b out_data=%h required 0 1 0 00",
                     busy, in_ready, out_valid, out_data);
        end
        send_txn(5'h01, F_ONE, F_ONE, F_TWO, 0);
        recv_all();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clock);
        end
        out_ready = 1'b0;
        checks++;
        if (seen) begin errors++; $display("FAIL extra_beat: out_valid seen=%b required 0", seen); end
    endtask

    task automatic test_back_to_back();
        send_txn(5'h04, F_ONE, F_1P5, F_1P5, 0);
        recv_all();
        send_txn(5'h01, F_TWO, F_ONE, F_THREE, 0);
        recv_all();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 5'h00;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_specials();
        test_backpressure();
        test_gapped_input();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
